// File: rtl/mpc_sequencer_if.sv
`default_nettype none
// mpc_sequencer_if: program-memory and datapath-control bundle for mpc_sequencer.
// master = sequencer, slave = memory/datapath side; step exists only with MPC_SEQ_STEP_EN.
interface mpc_sequencer_if #(
   parameter int DW   = 12,
   parameter int CNTW = 16
);
   logic            start;
   logic            mem_req;
   logic            mem_ack;
   logic [DW-1:0]   mem_data;
   logic            ovf;
   logic            cin;
   logic            ctrl_a;
   logic            ctrl_addr;
   logic            ctrl_pc;
   logic            we_a;
   logic            we_b;
   logic            we_pc;
   logic [DW-1:0]   data_out_seq;
   logic            busy;
   logic            halted;
   logic            illegal;
   logic [CNTW-1:0] retired;
`ifdef MPC_SEQ_STEP_EN
   logic            step;

   modport master (
      input  start, step, mem_ack, mem_data, ovf,
      output mem_req, cin, ctrl_a, ctrl_addr, ctrl_pc, we_a, we_b, we_pc,
             data_out_seq, busy, halted, illegal, retired
   );
   modport slave (
      output start, step, mem_ack, mem_data, ovf,
      input  mem_req, cin, ctrl_a, ctrl_addr, ctrl_pc, we_a, we_b, we_pc,
             data_out_seq, busy, halted, illegal, retired
   );
`else
   modport master (
      input  start, mem_ack, mem_data, ovf,
      output mem_req, cin, ctrl_a, ctrl_addr, ctrl_pc, we_a, we_b, we_pc,
             data_out_seq, busy, halted, illegal, retired
   );
   modport slave (
      output start, mem_ack, mem_data, ovf,
      input  mem_req, cin, ctrl_a, ctrl_addr, ctrl_pc, we_a, we_b, we_pc,
             data_out_seq, busy, halted, illegal, retired
   );
`endif
endinterface
`default_nettype wire

// File: rtl/mpc_sequencer.sv
`default_nettype none
// mpc_sequencer: fetch/decode/execute control sequencer for the mpc datapath, Rev 1.0.
// Define MPC_SEQ_STEP_EN for single-step mode (one instruction per STEP rising edge).
module mpc_sequencer #(
   parameter int DW   = 12,
   parameter int OPW  = 4,
   parameter int CNTW = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   mpc_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_PCUPD  = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [OPW-1:0] OP_NOP = OPW'(4'h0);
   localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
   localparam logic [OPW-1:0] OP_LDB = OPW'(4'h2);
   localparam logic [OPW-1:0] OP_ADD = OPW'(4'h3);
   localparam logic [OPW-1:0] OP_ADC = OPW'(4'h4);
   localparam logic [OPW-1:0] OP_JMP = OPW'(4'h5);
   localparam logic [OPW-1:0] OP_JOV = OPW'(4'h6);
   localparam logic [OPW-1:0] OP_HLT = OPW'(4'hF);

   state_t          state_q;
   logic [DW-1:0]   ir_q;
   logic [DW-1:0]   data_q;
   logic [DW-1:0]   data_d;
   logic [CNTW-1:0] retired_q;
   logic [CNTW-1:0] retired_d;
   logic            taken_q;
   logic            mem_req_q;
   logic            cin_q, ctrl_a_q, ctrl_pc_q, we_a_q, we_b_q, we_pc_q;
   logic            busy_q, halted_q, illegal_q;
   logic [OPW-1:0]  opcode;
   logic            step_issue;

   assign opcode    = ir_q[DW-1 -: OPW];
   assign data_d    = {{OPW{1'b0}}, ir_q[DW-OPW-1:0]};
   assign retired_d = (retired_q == {CNTW{1'b1}}) ? retired_q
                                                  : retired_q + {{(CNTW-1){1'b0}}, 1'b1};

`ifdef MPC_SEQ_STEP_EN
   // A rising edge seen outside an idle FETCH is remembered so no pulse is lost.
   localparam logic REQ_ON_ENTRY = 1'b0;
   logic step_q, step_pend_q, step_rise;

   assign step_rise  = bus.step & ~step_q;
   assign step_issue = (state_q == S_FETCH) && !mem_req_q && (step_rise || step_pend_q);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         step_q      <= 1'b0;
         step_pend_q <= 1'b0;
      end else begin
         step_q      <= bus.step;
         step_pend_q <= (step_pend_q | step_rise) & ~step_issue;
      end
   end
`else
   localparam logic REQ_ON_ENTRY = 1'b1;
   assign step_issue = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         ir_q      <= '0;
         data_q    <= '0;
         retired_q <= '0;
         taken_q   <= 1'b0;
         mem_req_q <= 1'b0;
         cin_q     <= 1'b0;
         ctrl_a_q  <= 1'b0;
         ctrl_pc_q <= 1'b0;
         we_a_q    <= 1'b0;
         we_b_q    <= 1'b0;
         we_pc_q   <= 1'b0;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         cin_q     <= 1'b0;
         ctrl_a_q  <= 1'b0;
         ctrl_pc_q <= 1'b0;
         we_a_q    <= 1'b0;
         we_b_q    <= 1'b0;
         we_pc_q   <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            S_IDLE, S_HALT: begin
               if (bus.start) begin
                  state_q   <= S_FETCH;
                  mem_req_q <= REQ_ON_ENTRY;
                  busy_q    <= 1'b1;
                  halted_q  <= 1'b0;
               end
            end
            S_FETCH: begin
               if (mem_req_q && bus.mem_ack) begin
                  ir_q      <= bus.mem_data;
                  mem_req_q <= 1'b0;
                  state_q   <= S_DECODE;
               end else if (step_issue) begin
                  mem_req_q <= 1'b1;
               end
            end
            S_DECODE: begin
               // Strobes are registered here so they cover exactly the EXEC cycle.
               taken_q <= bus.ovf;
               data_q  <= data_d;
               state_q <= S_EXEC;
               case (opcode)
                  OP_NOP, OP_HLT: begin end
                  OP_LDA: begin ctrl_a_q <= 1'b1; we_a_q <= 1'b1; end
                  OP_LDB: we_b_q <= 1'b1;
                  OP_ADD: we_a_q <= 1'b1;
                  OP_ADC: begin we_a_q <= 1'b1; cin_q <= 1'b1; end
                  OP_JMP: begin ctrl_pc_q <= 1'b1; we_pc_q <= 1'b1; end
                  OP_JOV: begin ctrl_pc_q <= bus.ovf; we_pc_q <= bus.ovf; end
                  default: illegal_q <= 1'b1;
               endcase
            end
            S_EXEC: begin
               retired_q <= retired_d;
               if (opcode == OP_HLT) begin
                  state_q  <= S_HALT;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else if (opcode == OP_JMP || (opcode == OP_JOV && taken_q)) begin
                  state_q   <= S_FETCH;
                  mem_req_q <= REQ_ON_ENTRY;
               end else begin
                  state_q <= S_PCUPD;
                  we_pc_q <= 1'b1;
               end
            end
            S_PCUPD: begin
               state_q   <= S_FETCH;
               mem_req_q <= REQ_ON_ENTRY;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.mem_req      = mem_req_q;
   assign bus.cin          = cin_q;
   assign bus.ctrl_a       = ctrl_a_q;
   assign bus.ctrl_addr    = 1'b0;
   assign bus.ctrl_pc      = ctrl_pc_q;
   assign bus.we_a         = we_a_q;
   assign bus.we_b         = we_b_q;
   assign bus.we_pc        = we_pc_q;
   assign bus.data_out_seq = data_q;
   assign bus.busy         = busy_q;
   assign bus.halted       = halted_q;
   assign bus.illegal      = illegal_q;
   assign bus.retired      = retired_q;
endmodule
`default_nettype wire

// File: tb/tb_mpc_sequencer.sv
`default_nettype none
// tb_mpc_sequencer: directed programs for mpc_sequencer checked against a per-cycle trace model.
module tb_mpc_sequencer;
   localparam int DW   = 12;
   localparam int CNTW = 4;
`ifdef MPC_SEQ_STEP_EN
   localparam int PRE = 2;
`else
   localparam int PRE = 0;
`endif

   typedef struct packed {
      logic mem_req, cin, ctrl_a, ctrl_addr, ctrl_pc, we_a, we_b, we_pc, busy, halted, illegal;
      logic [DW-1:0]   data;
      logic [CNTW-1:0] ret;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mpc_sequencer_if #(.DW(DW), .CNTW(CNTW)) bus ();
   mpc_sequencer #(.DW(DW), .OPW(4), .CNTW(CNTW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   int checks = 0, errors = 0, cyc = 0;
   int start_cyc = 0, halt_cyc = 0, req_run = 0, last_run = 0, ill_cnt = 0;
   logic halted_prev = 1'b0;
   exp_t expq[$];
   logic [DW-1:0]   m_data = '0;
   logic [CNTW-1:0] m_ret  = '0;

   function automatic exp_t act();
      return {bus.mem_req, bus.cin, bus.ctrl_a, bus.ctrl_addr, bus.ctrl_pc, bus.we_a, bus.we_b,
              bus.we_pc, bus.busy, bus.halted, bus.illegal, bus.data_out_seq, bus.retired};
   endfunction

   function automatic exp_t base(input logic req, input logic busy, input logic halted);
      exp_t e;
      e = '0;
      e.mem_req = req;
      e.busy    = busy;
      e.halted  = halted;
      e.data    = m_data;
      e.ret     = m_ret;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
      end
   endtask

   task automatic tick(input logic st, input logic ack, input logic [DW-1:0] md,
                       input logic ov, input logic stp, input exp_t e);
      @(posedge clk);
      #1;
      bus.start    = st;
      bus.mem_ack  = ack;
      bus.mem_data = md;
      bus.ovf      = ov;
`ifdef MPC_SEQ_STEP_EN
      bus.step     = stp;
`else
      if (stp) bus.ovf = ov;
`endif
      if (st) start_cyc = cyc + 1;
      expq.push_back(e);
   endtask

   // One instruction from its first FETCH cycle to the cycle after EXEC/PCUPD.
   task automatic instr(input logic [DW-1:0] w, input int wait_n, input logic ovf, input logic noise);
      logic [3:0] op;
      logic       taken;
      exp_t       e;
      op    = w[DW-1 -: 4];
      taken = (op == 4'h5) || (op == 4'h6 && ovf);
      for (int k = 0; k < PRE; k++) tick(noise, noise, ~w, ~ovf, k == PRE-1, base(1'b0, 1'b1, 1'b0));
      for (int k = 0; k <= wait_n; k++)
         tick(noise, k == wait_n, (k == wait_n) ? w : ~w, ~ovf, 1'b0, base(1'b1, 1'b1, 1'b0));
      tick(noise, noise, ~w, ovf, 1'b0, base(1'b0, 1'b1, 1'b0));
      m_data = {4'h0, w[DW-5:0]};
      e = base(1'b0, 1'b1, 1'b0);
      case (op)
         4'h0, 4'hF: begin end
         4'h1: begin e.ctrl_a = 1'b1; e.we_a = 1'b1; end
         4'h2: e.we_b = 1'b1;
         4'h3: e.we_a = 1'b1;
         4'h4: begin e.we_a = 1'b1; e.cin = 1'b1; end
         4'h5, 4'h6: begin e.ctrl_pc = taken; e.we_pc = taken; end
         default: e.illegal = 1'b1;
      endcase
      tick(noise && op != 4'hF, noise, ~w, ~ovf, 1'b0, e);
      if (m_ret != {CNTW{1'b1}}) m_ret = m_ret + 1'b1;
      if (op == 4'hF) begin
         tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      end else if (!taken) begin
         e = base(1'b0, 1'b1, 1'b0);
         e.we_pc = 1'b1;
         tick(noise, noise, ~w, ~ovf, 1'b0, e);
      end
   endtask

   always @(negedge clk) begin : cmp_p
      exp_t e;
      cyc++;
      if (bus.halted && !halted_prev) halt_cyc = cyc;
      halted_prev = bus.halted;
      if (bus.mem_req) req_run++;
      else begin
         if (req_run != 0) last_run = req_run;
         req_run = 0;
      end
      if (bus.illegal) ill_cnt++;
      if (expq.size() != 0) begin
         e = expq.pop_front();
         chk($sformatf("cycle %0d outputs", cyc), 32'(act()), 32'(e));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0; bus.mem_ack = 1'b0; bus.mem_data = '0; bus.ovf = 1'b0;
`ifdef MPC_SEQ_STEP_EN
      bus.step = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("reset outputs", 32'(act()), 32'd0);
      rst_n = 1'b1;
      repeat (2) tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b0));

      // LDA 0x07, LDB 0x19, ADD, HLT
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b0));
      instr(12'h107, 0, 1'b0, 1'b0);
      instr(12'h219, 0, 1'b0, 1'b0);
      instr(12'h300, 0, 1'b0, 1'b0);
      instr(12'hF00, 0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      chk("retired after program 1", 32'(bus.retired), 32'd4);
      chk("start to halted cycles", 32'(halt_cyc - start_cyc), 32'(16 + 4*PRE));

      // jumps, delayed ack, ignored ack/start, ADC, illegal opcode
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      instr(12'h620, 0, 1'b1, 1'b0);
      chk("jov target on data bus", 32'(bus.data_out_seq), 32'h020);
      instr(12'h621, 0, 1'b0, 1'b0);
      instr(12'h533, 0, 1'b0, 1'b0);
      instr(12'h1A5, 3, 1'b0, 1'b1);
      chk("delayed fetch request length", 32'(last_run), 32'd4);
      instr(12'h43C, 0, 1'b0, 1'b1);
      instr(12'hA55, 0, 1'b0, 1'b0);
      chk("illegal pulse cycles", 32'(ill_cnt), 32'd1);
      instr(12'h000, 0, 1'b0, 1'b0);
      instr(12'hF01, 0, 1'b0, 1'b0);

      // counter saturation
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      for (int i = 0; i < 6; i++) instr(12'h000, 0, 1'b0, 1'b0);
      instr(12'hF00, 0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      chk("retired saturated", 32'(bus.retired), 32'hF);

      // reset in the middle of FETCH
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(PRE == 0, 1'b1, 1'b0));
      @(posedge clk);
      #2;
      chk("request before reset", 32'(bus.mem_req), 32'(PRE == 0));
      rst_n = 1'b0;
      #1;
      chk("outputs in reset", 32'(act()), 32'd0);
      bus.mem_ack  = 1'b1;
      bus.mem_data = 12'h1FF;
      m_data = '0;
      m_ret  = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b1, 12'h1FF, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b0));
      tick(1'b1, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b0));
      instr(12'h1AB, 1, 1'b0, 1'b0);
      instr(12'hF00, 0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, '0, 1'b0, 1'b0, base(1'b0, 1'b0, 1'b1));
      chk("retired after reset run", 32'(bus.retired), 32'd2);

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
